// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register dump scanner.
// Holds the scan FSM state encoding, the byte-slot type and the index-byte tag default.
// No logic lives here apart from a small byte-select helper.
package reg_dump_pkg;

  // Scan FSM states. CSUM is reachable only when REG_DUMP_CHECKSUM_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEL  = 3'd1,
    ST_CAP  = 3'd2,
    ST_SEND = 3'd3,
    ST_CSUM = 3'd4,
    ST_FIN  = 3'd5
  } state_e;

  localparam int BYTES_PER_REG = 5;
  localparam logic [2:0] IDX_TAG_DEFAULT = 3'b101;

  // Byte slot within one register's record: 0 = index byte, 1..4 = data bytes LSB first.
  typedef logic [2:0] slot_t;
  localparam slot_t LAST_SLOT = slot_t'(BYTES_PER_REG - 1);

  // Data byte for slots 1..4; slot 0 (the index byte) is built by the caller.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input slot_t s);
    logic [7:0] b;
    b = 8'h00;
    case (s)
      3'd1:    b = w[7:0];
      3'd2:    b = w[15:8];
      3'd3:    b = w[23:16];
      3'd4:    b = w[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/reg_dump_ser.sv
// Purpose : serialise one captured register as {tag,index}, d[7:0], d[15:8], d[23:16], d[31:24].
// Latency : first byte valid the cycle after i_load; one byte per accepted handshake.
// Backpr. : o_tx_data/o_tx_valid held stable until o_tx_valid && i_tx_ready.
// Ports   : i_clk, i_rst (async, active-high), i_load/i_word/i_idx load a record,
//           o_tx_data/o_tx_valid/i_tx_ready stream, o_last_acc pulses when slot 4 is accepted.
module reg_dump_ser
  import reg_dump_pkg::*;
#(
  parameter logic [2:0] IDX_TAG = IDX_TAG_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:0] i_word,
  input  logic [4:0]  i_idx,
  input  logic        i_tx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  output logic        o_last_acc
);

  logic [31:0] r_word;
  slot_t       r_slot;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        w_acc;
  slot_t       w_slot_nxt;

  assign w_acc      = r_valid & i_tx_ready;
  assign w_slot_nxt = slot_t'(r_slot + 3'd1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_word  <= 32'h0;
      r_slot  <= '0;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
    end else if (i_load) begin
      // The holding register is the capture point for reg_data.
      r_word  <= i_word;
      r_slot  <= '0;
      r_data  <= {IDX_TAG, i_idx};
      r_valid <= 1'b1;
    end else if (w_acc) begin
      if (r_slot == LAST_SLOT) begin
        r_valid <= 1'b0;
        r_slot  <= '0;
      end else begin
        r_slot <= w_slot_nxt;
        r_data <= word_byte(r_word, w_slot_nxt);
      end
    end
  end

  assign o_tx_data  = r_data;
  assign o_tx_valid = r_valid;
  assign o_last_acc = w_acc && (r_slot == LAST_SLOT);

endmodule

// File: rtl/reg_dump_scanner.sv
// Purpose : on one start pulse, walk reg_sel over 0..NREG-1 and stream 5 bytes per register.
// Latency : start at edge k -> first tx_valid at edge k+SETTLE+1; >= SETTLE+6 cycles per register.
// Backpr. : stream advances only on tx_valid && tx_ready; stalled bytes are held stable.
// Ports   : clk, rst (async, active-high), start, busy, done, reg_sel/reg_data (regfile debug
//           port), tx_data/tx_valid/tx_ready (byte stream).
// Option  : REG_DUMP_CHECKSUM_EN appends one byte making the stream sum 0 mod 256.
module reg_dump_scanner
  import reg_dump_pkg::*;
#(
  parameter int         NREG    = 32,
  parameter int         SETTLE  = 1,
  parameter logic [2:0] IDX_TAG = IDX_TAG_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam logic [4:0] LAST_IDX  = 5'(NREG - 1);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  state_e     r_state;
  logic [4:0] r_index;
  logic [4:0] r_sel;
  logic [3:0] r_settle;
  logic       r_busy;
  logic       r_done;

  logic       w_load;
  logic       w_last_acc;
  logic       w_ser_vld;
  logic [7:0] w_ser_dat;
  logic       w_last_reg;

  assign w_load     = (r_state == ST_CAP);
  assign w_last_reg = (r_index == LAST_IDX);

  reg_dump_ser #(
    .IDX_TAG (IDX_TAG)
  ) u_ser (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_load),
    .i_word     (reg_data),
    .i_idx      (r_index),
    .i_tx_ready (tx_ready),
    .o_tx_data  (w_ser_dat),
    .o_tx_valid (w_ser_vld),
    .o_last_acc (w_last_acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_index  <= 5'd0;
      r_sel    <= 5'd0;
      r_settle <= 4'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state  <= ST_SEL;
            r_busy   <= 1'b1;
            r_index  <= 5'd0;
            r_sel    <= 5'd0;
            r_settle <= SETTLE_LD;
          end
        end
        ST_SEL: begin
          // SEL lasts exactly SETTLE cycles so reg_data has settled by the CAP edge.
          if (r_settle <= 4'd1) begin
            r_settle <= 4'd0;
            r_state  <= ST_CAP;
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end
        ST_CAP: begin
          r_state <= ST_SEND;
        end
        ST_SEND: begin
          if (w_last_acc) begin
            if (w_last_reg) begin
`ifdef REG_DUMP_CHECKSUM_EN
              r_state <= ST_CSUM;
`else
              r_state <= ST_FIN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
`endif
            end else begin
              r_index  <= r_index + 5'd1;
              r_sel    <= r_index + 5'd1;
              r_settle <= SETTLE_LD;
              r_state  <= ST_SEL;
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        ST_CSUM: begin
          if (tx_ready) begin
            r_state <= ST_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
`endif
        ST_FIN: begin
          // start is deliberately not looked at here.
          r_done  <= 1'b0;
          r_sel   <= 5'd0;
          r_index <= 5'd0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef REG_DUMP_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] r_csum;
  logic [7:0] w_sum_nxt;

  assign w_sum_nxt = r_sum + w_ser_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= 8'h00;
      r_csum <= 8'h00;
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_sum <= 8'h00;
      end else if (w_ser_vld && tx_ready) begin
        r_sum <= w_sum_nxt;
      end
      // Final data byte is folded in here since r_sum only sees it at this same edge.
      if (w_last_acc && w_last_reg) begin
        r_csum <= 8'h00 - w_sum_nxt;
      end
    end
  end

  assign tx_valid = w_ser_vld | (r_state == ST_CSUM);
  assign tx_data  = (r_state == ST_CSUM) ? r_csum : w_ser_dat;
`else
  assign tx_valid = w_ser_vld;
  assign tx_data  = w_ser_dat;
`endif

  assign busy    = r_busy;
  assign done    = r_done;
  assign reg_sel = r_sel;

endmodule

// File: tb/tb_reg_dump_scanner.sv
module tb_reg_dump_scanner;

  localparam int NREG   = 32;
  localparam int SETTLE = 3;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int TOTAL = 5 * NREG + 1;
`else
  localparam int TOTAL = 5 * NREG;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  always #5 clk = ~clk;

  reg_dump_scanner #(.NREG(NREG), .SETTLE(SETTLE)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .reg_sel  (reg_sel),
    .reg_data (reg_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  // Register file model: new value appears 2 cycles after reg_sel changes, stale data before.
  logic [31:0] regs [NREG];
  logic [4:0]  sel_d1 = 5'd0;
  logic [4:0]  sel_d2 = 5'd0;
  always @(posedge clk) begin
    sel_d1 <= reg_sel;
    sel_d2 <= sel_d1;
  end
  assign reg_data = (sel_d1 == reg_sel && sel_d2 == reg_sel) ? regs[reg_sel] : 32'hDEAD_BEEF;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int checks = 0;
  int errors = 0;
  int ptr = 0;
  int done_cnt = 0;
  int ready_pct = 100;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected stream straight from the register contents.
  function automatic void build();
    int sum;
    logic [7:0] t;
    sum = 0;
    exp_q.delete();
    for (int r = 0; r < NREG; r++) begin
      t = {3'b101, 5'(r)};
      exp_q.push_back(t);
      for (int b = 0; b < 4; b++) exp_q.push_back(8'(regs[r] >> (8 * b)));
    end
`ifdef REG_DUMP_CHECKSUM_EN
    foreach (exp_q[i]) sum += int'(exp_q[i]);
    exp_q.push_back(8'((256 - (sum % 256)) % 256));
`endif
  endfunction

  // Compare process: all outputs checked on every falling edge outside reset.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dat = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(tx_valid), 32'd1);
        check("stall_data", 32'(tx_data), 32'(prev_dat));
      end
      if (tx_valid) begin
        check("busy_during_tx", 32'(busy), 32'd1);
        if (ptr < 5 * NREG) check("reg_sel_pending", 32'(reg_sel), 32'(ptr / 5));
      end
      if (!busy && !done) begin
        check("idle_reg_sel", 32'(reg_sel), 32'd0);
        check("idle_valid", 32'(tx_valid), 32'd0);
      end
      if (tx_valid && tx_ready) begin
        if (ptr < exp_q.size()) check("byte", 32'(tx_data), 32'(exp_q[ptr]));
        else check("extra_byte", 32'(ptr), 32'(exp_q.size()));
        got_q.push_back(tx_data);
        ptr++;
      end
      if (done) begin
        done_cnt++;
        check("done_all_bytes", 32'(ptr), 32'(exp_q.size()));
        check("done_busy", 32'(busy), 32'd0);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_dat   = tx_data;
    end
  end

  // Sink readiness, redrawn every cycle.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_dump();
    ptr = 0;
    done_cnt = 0;
    got_q.delete();
    build();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit fin_pulse);
    int c;
    c = 0;
    while (!done && c < 5000) begin
      tick();
      c++;
    end
    check("done_seen", 32'(done), 32'd1);
    if (fin_pulse && done) pulse_start();
  endtask

  task automatic post_checks();
    repeat (10) tick();
    check("done_count", 32'(done_cnt), 32'd1);
    check("stream_len", 32'(got_q.size()), 32'(TOTAL));
    check("busy_after", 32'(busy), 32'd0);
    check("valid_after", 32'(tx_valid), 32'd0);
  endtask

  initial begin
    int n;
    int sum;
    rst = 1'b1;
    start = 1'b0;
    for (int r = 0; r < NREG; r++) regs[r] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_reg_sel", 32'(reg_sel), 32'd0);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    rst = 1'b0;
    tick();

    // Full dump, sink always ready, latency measured.
    for (int r = 0; r < NREG; r++) regs[r] = 32'h1000_0000 + 32'(r);
    ready_pct = 100;
    begin_dump();
    check("model_byte0", 32'(exp_q[0]), 32'hA0);
    check("model_byte155", 32'(exp_q[155]), 32'hBF);
    start = 1'b1;
    tick();
    check("busy_after_start", 32'(busy), 32'd1);
    start = 1'b0;
    n = 0;
    while (!tx_valid && n < 40) begin
      tick();
      n++;
    end
    check("first_valid_latency", 32'(n), 32'(SETTLE + 1));
    wait_done(1'b0);
    post_checks();
    check("pin_first", 32'(got_q.size() > 0 ? got_q[0] : 8'h00), 32'hA0);
    check("pin_byte4", 32'(got_q.size() > 4 ? got_q[4] : 8'h00), 32'h10);
    check("pin_byte156", 32'(got_q.size() > 156 ? got_q[156] : 8'h00), 32'h1F);

    // Random contents, sink ready 30% of cycles.
    for (int r = 0; r < NREG; r++) regs[r] = $urandom;
    ready_pct = 30;
    begin_dump();
    pulse_start();
    wait_done(1'b0);
    post_checks();

    // Held start, mid-dump start, start during FIN: still one dump.
    for (int r = 0; r < NREG; r++) regs[r] = 32'h1000_0000 + 32'(r);
    ready_pct = 100;
    begin_dump();
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    repeat (40) tick();
    pulse_start();
    wait_done(1'b1);
    post_checks();

    // Reset after 7 accepted bytes, then a clean restart.
    for (int r = 0; r < NREG; r++) regs[r] = $urandom;
    ready_pct = 60;
    begin_dump();
    pulse_start();
    n = 0;
    while (ptr < 7 && n < 2000) begin
      tick();
      n++;
    end
    check("bytes_before_reset", 32'(ptr), 32'd7);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(tx_valid), 32'd0);
    check("midrst_reg_sel", 32'(reg_sel), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    begin_dump();
    pulse_start();
    wait_done(1'b0);
    post_checks();
    check("restart_first", 32'(got_q.size() > 0 ? got_q[0] : 8'h00), 32'hA0);

    // All-zero registers: index bytes only (checksum byte when enabled).
    for (int r = 0; r < NREG; r++) regs[r] = 32'h0;
    ready_pct = 50;
    begin_dump();
    pulse_start();
    wait_done(1'b0);
    post_checks();
    check("zero_last_idx", 32'(got_q.size() > 155 ? got_q[155] : 8'h00), 32'hBF);
`ifdef REG_DUMP_CHECKSUM_EN
    check("csum_byte", 32'(got_q.size() > 160 ? got_q[160] : 8'h00), 32'h10);
    sum = 0;
    foreach (got_q[i]) sum += int'(got_q[i]);
    check("csum_total", 32'(sum % 256), 32'd0);
`else
    check("zero_last_byte", 32'(got_q.size() > 159 ? got_q[159] : 8'hFF), 32'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
